// File: rtl/text_buffer_ctrl.sv
// Character-buffer controller for the VGA text display: turns a byte stream into
// cursor moves and writes into a COLS x ROWS character RAM with a registered read port.
module text_buffer_ctrl #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [6:0]       rd_char,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             busy
);

  localparam int unsigned Depth = COLS * ROWS;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [6:0]  Blank = 7'h20;

  typedef enum logic [1:0] {StClrAll, StIdle, StClrRow} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] row_adv;

  logic             we;
  logic [AddrW-1:0] waddr;
  logic [6:0]       wdata;
  logic [AddrW-1:0] raddr;
  logic             raddr_ok;

  logic [6:0] mem [Depth];

  function automatic logic [AddrW-1:0] addr_of(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
    return AddrW'(r) * AddrW'(COLS) + AddrW'(c);
  endfunction

  // No scrolling: the row after the last one is row 0.
  assign row_adv = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StClrAll;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = Blank;
    unique case (state_q)
      StClrAll: begin
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == AddrW'(Depth - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClrRow: begin
        we    = 1'b1;
        waddr = addr_of(row_q, COL_W'(cnt_q));
        if (cnt_q == AddrW'(COLS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (rx_valid) begin
          case (rx_data)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d   = '0;
              row_d   = row_adv;
              cnt_d   = '0;
              state_d = StClrRow;
            end
            8'h08: begin
              if (col_q != '0) begin
                col_d = col_q - 1'b1;
                we    = 1'b1;
                waddr = addr_of(row_q, col_q - 1'b1);
              end
            end
            8'h0C: begin
              cnt_d   = '0;
              state_d = StClrAll;
            end
            default: begin
              if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                we    = 1'b1;
                waddr = addr_of(row_q, col_q);
                wdata = rx_data[6:0];
                if (col_q < COL_W'(COLS - 1)) begin
                  col_d = col_q + 1'b1;
                end else begin
                  col_d   = '0;
                  row_d   = row_adv;
                  cnt_d   = '0;
                  state_d = StClrRow;
                end
              end
            end
          endcase
        end
      end
      default: state_d = StClrAll;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign raddr    = addr_of(rd_row, rd_col);
  assign raddr_ok = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);

  // Non-blocking read beside the write block gives read-first behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_char <= Blank;
    else       rd_char <= raddr_ok ? mem[raddr] : Blank;
  end

  assign rx_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Bench for text_buffer_ctrl: directed vector table, corner sequences and random bytes
// checked against a screen/cursor model applied one accepted byte at a time.
module tb_text_buffer_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;
  localparam int LIMIT = 5000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [6:0] rd_col = '0;
  logic [4:0] rd_row = '0;
  logic [6:0] rd_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int m_mem[NCELL];
  int m_col, m_row;

  typedef struct {
    logic [7:0] b;
    int col, row, clr, rr, rc, rv;
  } vec_t;
  vec_t tbl[17];

  text_buffer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_char   (rd_char),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NCELL; i++) m_mem[i] = 32'h20;
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void m_clear_row(input int r);
    for (int c = 0; c < COLS; c++) m_mem[r * COLS + c] = 32'h20;
  endfunction

  // Applies one accepted byte; returns how many cycles the controller should stay busy.
  function automatic int m_apply(input int b);
    if (b >= 32'h20 && b <= 32'h7E) begin
      m_mem[m_row * COLS + m_col] = b;
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        m_clear_row(m_row);
        return COLS;
      end
    end else if (b == 32'h0D) begin
      m_col = 0;
    end else if (b == 32'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      m_clear_row(m_row);
      return COLS;
    end else if (b == 32'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row * COLS + m_col] = 32'h20;
      end
    end else if (b == 32'h0C) begin
      m_reset();
      return NCELL;
    end
    return 0;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (rx_ready !== 1'b1 && n < LIMIT) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // junk=1 keeps rx_valid high with a printable byte while the controller is busy.
  task automatic send(input logic [7:0] b, input bit junk, output int clr);
    int n;
    int exp;
    wait_ready(n);
    chk("ready_before_send", rx_ready, 1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    exp = m_apply(int'(b));
    if (junk) rx_data = 8'h41;
    else rx_valid = 1'b0;
    chk("busy_after_accept", busy, exp > 0);
    clr = 0;
    while (rx_ready !== 1'b1 && clr < LIMIT) begin
      clr++;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    chk("busy_cycles", clr, exp);
    chk("cursor_col", cursor_col, m_col);
    chk("cursor_row", cursor_row, m_row);
  endtask

  task automatic read_cell(input int r, input int c, output logic [6:0] v);
    rd_row = 5'(r);
    rd_col = 7'(c);
    @(posedge clk);
    #1;
    v = rd_char;
  endtask

  task automatic check_screen(input string name);
    logic [6:0] v;
    int bad = 0;
    int fr = 0, fc = 0, fv = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        if (int'(v) !== m_mem[r * COLS + c]) begin
          if (bad == 0) begin fr = r; fc = c; fv = int'(v); end
          bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d cells differ, first (%0d,%0d) got 0x%0h expected 0x%0h",
               name, bad, fr, fc, fv, m_mem[fr * COLS + fc]);
    end
  endtask

  task automatic check_row(input string name, input int r, input int val);
    logic [6:0] v;
    int bad = 0;
    int fc = 0, fv = 0;
    for (int c = 0; c < COLS; c++) begin
      read_cell(r, c, v);
      if (int'(v) !== val) begin
        if (bad == 0) begin fc = c; fv = int'(v); end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: row %0d has %0d bad cells, col %0d got 0x%0h expected 0x%0h",
               name, r, bad, fc, fv, val);
    end
  endtask

  initial begin
    int n, clr;
    logic [6:0] v;
    logic [7:0] b;
    int ff_left;

    tbl[0]  = '{8'h41, 1, 0, 0, 0, 0, 32'h41};
    tbl[1]  = '{8'h42, 2, 0, 0, 0, 1, 32'h42};
    tbl[2]  = '{8'h08, 1, 0, 0, 0, 1, 32'h20};
    tbl[3]  = '{8'h41, 2, 0, 0, 0, 1, 32'h41};
    tbl[4]  = '{8'h08, 1, 0, 0, 0, 1, 32'h20};
    tbl[5]  = '{8'h08, 0, 0, 0, 0, 0, 32'h20};
    tbl[6]  = '{8'h08, 0, 0, 0, 0, 0, 32'h20};
    tbl[7]  = '{8'h07, 0, 0, 0, 0, 0, 32'h20};
    tbl[8]  = '{8'h5A, 1, 0, 0, 0, 0, 32'h5A};
    tbl[9]  = '{8'h0D, 0, 0, 0, 0, 0, 32'h5A};
    tbl[10] = '{8'h0A, 0, 1, 80, 1, 0, 32'h20};
    tbl[11] = '{8'hC1, 0, 1, 0, 1, 0, 32'h20};
    tbl[12] = '{8'h7F, 0, 1, 0, 0, 0, 32'h5A};
    tbl[13] = '{8'h7E, 1, 1, 0, 1, 0, 32'h7E};
    tbl[14] = '{8'h20, 2, 1, 0, 1, 1, 32'h20};
    tbl[15] = '{8'h00, 2, 1, 0, 1, 0, 32'h7E};
    tbl[16] = '{8'h1B, 2, 1, 0, 0, 0, 32'h5A};

    // Reset state and initial full clear.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_busy", busy, 1);
    chk("reset_cursor_col", cursor_col, 0);
    chk("reset_cursor_row", cursor_row, 0);
    chk("reset_rd_char", rd_char, 32'h20);
    reset = 1'b0;
    m_reset();
    wait_ready(n);
    chk("init_clear_cycles", n, NCELL);
    chk("init_cursor_col", cursor_col, 0);
    chk("init_cursor_row", cursor_row, 0);
    check_screen("init_screen");

    // Directed vectors.
    foreach (tbl[i]) begin
      send(tbl[i].b, 1'b0, clr);
      chk($sformatf("vec%0d_col", i), cursor_col, tbl[i].col);
      chk($sformatf("vec%0d_row", i), cursor_row, tbl[i].row);
      chk($sformatf("vec%0d_clr", i), clr, tbl[i].clr);
      read_cell(tbl[i].rr, tbl[i].rc, v);
      chk($sformatf("vec%0d_rd", i), v, tbl[i].rv);
    end
    check_screen("vec_screen");

    // Reset in the middle of a row clear.
    wait_ready(n);
    rx_data  = 8'h0A;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    clr = m_apply(32'h0A);
    chk("midclr_row_before_reset", cursor_row, 2);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midclr_reset_col", cursor_col, 0);
    chk("midclr_reset_row", cursor_row, 0);
    chk("midclr_reset_ready", rx_ready, 0);
    chk("midclr_reset_busy", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    wait_ready(n);
    chk("midclr_full_clear_cycles", n, NCELL);

    // Preload row 1, wrap back to row 0, then fill row 0 so the cursor wraps onto row 1.
    send(8'h0A, 1'b0, clr);
    for (int i = 0; i < COLS - 1; i++) send(8'h58, 1'b0, clr);
    send(8'h0D, 1'b0, clr);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 1'b0, clr);
    chk("wrap_start_row", cursor_row, 0);
    for (int i = 0; i < COLS; i++) send(8'h2A, 1'b1, clr);
    chk("row_fill_clr", clr, COLS);
    chk("row_fill_col", cursor_col, 0);
    chk("row_fill_row", cursor_row, 1);
    check_row("row0_all_star", 0, 32'h2A);
    check_row("row1_cleared", 1, 32'h20);

    // LF on the last row wraps to row 0 and leaves the last row alone.
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 1'b0, clr);
    for (int i = 0; i < 5; i++) send(8'h4D, 1'b0, clr);
    chk("last_row_col", cursor_col, 5);
    chk("last_row_row", cursor_row, ROWS - 1);
    send(8'h0A, 1'b0, clr);
    chk("last_lf_clr", clr, COLS);
    chk("last_lf_col", cursor_col, 0);
    chk("last_lf_row", cursor_row, 0);
    check_row("last_lf_row0", 0, 32'h20);
    read_cell(ROWS - 1, 0, v);
    chk("last_row_kept0", v, 32'h4D);
    read_cell(ROWS - 1, 4, v);
    chk("last_row_kept4", v, 32'h4D);
    read_cell(ROWS - 1, 5, v);
    chk("last_row_blank5", v, 32'h20);

    // Random byte stream against the model.
    ff_left = 2;
    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 70) b = 8'($urandom_range(32'h20, 32'h7E));
      else if (sel < 78) b = 8'h0D;
      else if (sel < 85) b = 8'h0A;
      else if (sel < 93) b = 8'h08;
      else if (sel < 98 || ff_left == 0) begin
        do b = 8'($urandom_range(0, 255));
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A || b == 8'h0C
               || b == 8'h0D);
      end else begin
        b = 8'h0C;
        ff_left--;
      end
      send(b, 1'($urandom_range(0, 1)), clr);
      if (i % 50 == 49) check_screen($sformatf("rand_screen_%0d", i));
    end

    // Form feed after text clears everything.
    send(8'h48, 1'b0, clr);
    send(8'h49, 1'b0, clr);
    send(8'h0C, 1'b1, clr);
    chk("ff_clr", clr, NCELL);
    chk("ff_col", cursor_col, 0);
    chk("ff_row", cursor_row, 0);
    check_screen("ff_screen");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
